multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequential signed 32-bit multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// Both take 32 iterations and report through a one-cycle data_resultRDY pulse.
module multdiv_ctrl (
    input  logic        clk,
    input  logic        ctrl_reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic [4:0]  iterCnt_r;

    // Multiply working register {acc, mplr, boothBit} and the multiplicand.
    logic [64:0] booth_r;
    logic [31:0] mcand_r;

    // Divide working registers; magnitudes only, sign and special cases kept aside.
    logic [31:0] quot_r;
    logic [31:0] rem_r;
    logic [31:0] divisor_r;
    logic        negQuot_r;
    logic        divZero_r;
    logic        divOvf_r;

    logic [31:0] result_r;
    logic        exception_r;
    logic        resultRdy_r;

    logic        start_s;
    logic        lastIter_s;
    logic        multDone_s;
    logic        divDone_s;

    logic [32:0] boothSum_s;
    logic [64:0] boothNext_s;
    logic        multOvf_s;

    logic [32:0] remShift_s;
    logic [32:0] remDiff_s;
    logic [31:0] remNext_s;
    logic [31:0] quotNext_s;
    logic [31:0] divResult_s;

    function automatic logic [31:0] absVal(input logic [31:0] v);
        absVal = v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic allSame(input logic [32:0] v);
        allSame = (&v) | (~|v);
    endfunction

    assign start_s    = ctrl_MULT | ctrl_DIV;
    assign lastIter_s = (iterCnt_r == 5'd31);
    assign multDone_s = (state_r == MULT_RUN) && lastIter_s && !start_s;
    assign divDone_s  = (state_r == DIV_RUN) && lastIter_s && !start_s;

    // Booth step: the sum is kept at 33 bits so the shift uses the true sign,
    // which keeps mcand = 0x80000000 correct without widening the register.
    always_comb begin
        boothSum_s  = {booth_r[64], booth_r[64:33]};
        case (booth_r[1:0])
            2'b01:   boothSum_s = {booth_r[64], booth_r[64:33]} + {mcand_r[31], mcand_r};
            2'b10:   boothSum_s = {booth_r[64], booth_r[64:33]} - {mcand_r[31], mcand_r};
            default: boothSum_s = {booth_r[64], booth_r[64:33]};
        endcase
        boothNext_s = {boothSum_s, booth_r[32:1]};
        multOvf_s   = !allSame(boothNext_s[64:32]);
    end

    // Restoring divide step on magnitudes plus final sign/special-case selection.
    always_comb begin
        remShift_s = {rem_r, quot_r[31]};
        remDiff_s  = remShift_s - {1'b0, divisor_r};
        if (!remDiff_s[32]) begin
            remNext_s  = remDiff_s[31:0];
            quotNext_s = {quot_r[30:0], 1'b1};
        end else begin
            remNext_s  = remShift_s[31:0];
            quotNext_s = {quot_r[30:0], 1'b0};
        end
        if (divZero_r) begin
            divResult_s = 32'd0;
        end else if (negQuot_r) begin
            divResult_s = 32'd0 - quotNext_s;
        end else begin
            divResult_s = quotNext_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; a start wins from any state, multiply over divide.
    always_comb begin
        nextState_s = state_r;
        if (ctrl_MULT) begin
            nextState_s = MULT_RUN;
        end else if (ctrl_DIV) begin
            nextState_s = DIV_RUN;
        end else begin
            case (state_r)
                IDLE:     nextState_s = IDLE;
                MULT_RUN: nextState_s = lastIter_s ? DONE : MULT_RUN;
                DIV_RUN:  nextState_s = lastIter_s ? DONE : DIV_RUN;
                DONE:     nextState_s = IDLE;
                default:  nextState_s = IDLE;
            endcase
        end
    end

    // Datapath: operand capture on start, one iteration per edge while running.
    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            iterCnt_r   <= 5'd0;
            booth_r     <= 65'd0;
            mcand_r     <= 32'd0;
            quot_r      <= 32'd0;
            rem_r       <= 32'd0;
            divisor_r   <= 32'd0;
            negQuot_r   <= 1'b0;
            divZero_r   <= 1'b0;
            divOvf_r    <= 1'b0;
            result_r    <= 32'd0;
            exception_r <= 1'b0;
        end else if (start_s) begin
            iterCnt_r <= 5'd0;
            booth_r   <= {32'd0, data_operandB, 1'b0};
            mcand_r   <= data_operandA;
            quot_r    <= absVal(data_operandA);
            rem_r     <= 32'd0;
            divisor_r <= absVal(data_operandB);
            negQuot_r <= data_operandA[31] ^ data_operandB[31];
            divZero_r <= (data_operandB == 32'd0);
            divOvf_r  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else begin
            case (state_r)
                MULT_RUN: begin
                    iterCnt_r <= iterCnt_r + 5'd1;
                    booth_r   <= boothNext_s;
                    if (lastIter_s) begin
                        result_r    <= boothNext_s[32:1];
                        exception_r <= multOvf_s;
                    end
                end
                DIV_RUN: begin
                    iterCnt_r <= iterCnt_r + 5'd1;
                    quot_r    <= quotNext_s;
                    rem_r     <= remNext_s;
                    if (lastIter_s) begin
                        result_r    <= divResult_s;
                        exception_r <= divZero_r | divOvf_r;
                    end
                end
                default: begin
                    iterCnt_r <= iterCnt_r;
                end
            endcase
        end
    end

    // Done pulse: high only in the cycle following the final iteration.
    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            resultRdy_r <= 1'b0;
        end else begin
            resultRdy_r <= multDone_s | divDone_s;
        end
    end

    assign data_result    = result_r;
    assign data_exception = exception_r;
    assign data_resultRDY = resultRdy_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected results with the
// cycle the done pulse must appear in; a negedge monitor pops and compares.
module tb_multdiv_ctrl;

    logic        clk;
    logic        ctrl_reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    multdiv_ctrl dut (
        .clk            (clk),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a start for one edge; expected result is due 32 edges after that edge.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] res, input logic exc);
        exp_t e;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.cyc = cyc + 32;
            expQ.push_back(e);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (expQ.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                chk("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        waitCycles(3);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        ctrl_reset = 1'b0;

        // First edge after reset starts a multiply.
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
        waitCycles(33);

        // A new start leaves the previous result visible.
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        waitCycles(5);
        chk("hold_result", data_result, 32'hFFFF_FFEB);
        chk("hold_exc", {31'd0, data_exception}, 32'd0);
        waitCycles(28);

        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1);
        waitCycles(33);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b0);
        waitCycles(33);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'd2, 1'b1, 32'h0000_0000, 1'b1);
        waitCycles(33);
        issue(1'b0, 1'b1, 32'd100, 32'd0, 1'b1, 32'd0, 1'b1);
        waitCycles(33);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        waitCycles(33);
        issue(1'b0, 1'b1, 32'd50, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF9, 1'b0);
        waitCycles(33);

        // Abort a multiply with a divide ten edges later.
        issue(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0);
        waitCycles(9);
        issue(1'b0, 1'b1, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);
        waitCycles(33);

        // Reset mid-multiply cancels it and clears the result.
        issue(1'b1, 1'b0, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0);
        waitCycles(14);
        ctrl_reset = 1'b1;
        waitCycles(1);
        ctrl_reset = 1'b0;
        waitCycles(40);
        chk("rst_result", data_result, 32'd0);
        chk("rst_exc", {31'd0, data_exception}, 32'd0);
        issue(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
        waitCycles(33);

        // Both starts together multiply; restart in the done cycle.
        issue(1'b1, 1'b1, 32'd12, 32'd4, 1'b1, 32'd48, 1'b0);
        waitCycles(32);
        issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd9, 1'b1, 32'hFFFF_FFD3, 1'b0);
        waitCycles(33);

        // Reset on the same edge as a start drops the start.
        ctrl_reset = 1'b1;
        issue(1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0);
        ctrl_reset = 1'b0;
        waitCycles(40);

        chk("queue_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
